// File: rtl/fc_stream_driver.sv
// Packs a serial activation stream into one FC input vector, pulses the FC enable,
// captures the FC's registered result and offers it downstream on a valid/ready port.
module fc_stream_driver #(
  parameter int N_IN = 16,
  parameter int DW   = 10,
  parameter int RW   = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_s_valid,
  input  logic [DW-1:0]      i_s_data,
  output logic               o_s_ready,
  output logic               o_fc_enable,
  output logic [N_IN*DW-1:0] o_fc_data,
  input  logic [RW-1:0]      i_fc_result,
  output logic               o_m_valid,
  output logic [RW-1:0]      o_m_result,
  input  logic               i_m_ready,
  output logic [4:0]         o_count,
  output logic [1:0]         o_state
);

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_FIRE    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and an offered item stays stable
  // until it is taken.
  logic [1:0]         state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [N_IN*DW-1:0] data_q, data_d;
  logic [RW-1:0]      result_q, result_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    result_d = result_q;
    if (i_clear) begin
      state_d = ST_FILL;
      count_d = 5'd0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (i_s_valid) begin
            data_d[int'(count_q) * DW +: DW] = i_s_data;
            count_d = count_q + 5'd1;
            if (count_q == 5'(N_IN - 1)) state_d = ST_FIRE;
          end
        end
        ST_FIRE:    state_d = ST_CAPTURE;
        // The FC registered its result on the FIRE edge, so it is valid now.
        ST_CAPTURE: begin
          result_d = i_fc_result;
          state_d  = ST_OUT;
        end
        ST_OUT: begin
          if (i_m_ready) begin
            count_d = 5'd0;
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_FILL;
      count_q  <= 5'd0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  // Enable is gated by clear so an aborted FIRE cycle never reaches the FC.
  assign o_fc_enable = (state_q == ST_FIRE) && !i_clear;
  assign o_s_ready   = (state_q == ST_FILL);
  assign o_m_valid   = (state_q == ST_OUT);
  assign o_m_result  = result_q;
  assign o_fc_data   = data_q;
  assign o_count     = count_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_fc_stream_driver.sv
// Bench for fc_stream_driver: a behavioural FC layer plus a transaction-level model
// of the driver, compared against the DUT every cycle under directed and random stimulus.
module tb_fc_stream_driver;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         sv;
  logic [9:0]   sd;
  logic         mr;
  logic         s_ready;
  logic         fc_en;
  logic [159:0] fc_data;
  logic [31:0]  fc_result = '0;
  logic         m_valid;
  logic [31:0]  m_result;
  logic [4:0]   cnt;
  logic [1:0]   st_dbg;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  fc_stream_driver #(.N_IN(16), .DW(10), .RW(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clr),
    .i_s_valid(sv), .i_s_data(sd), .o_s_ready(s_ready),
    .o_fc_enable(fc_en), .o_fc_data(fc_data), .i_fc_result(fc_result),
    .o_m_valid(m_valid), .o_m_result(m_result), .i_m_ready(mr),
    .o_count(cnt), .o_state(st_dbg)
  );

  // FC layer: weights sum to 211, bias 238, weight[4] = -522.
  int w [16] = '{100, -50, 200, 33, -522, 150, -20, 80, 60, -40, 90, 10, -70, 55, 45, 90};

  function automatic logic [31:0] fc_eval(input logic [159:0] v);
    int acc;
    acc = 238;
    for (int k = 0; k < 16; k++) acc += int'($signed(v[k*10 +: 10])) * w[k];
    return 32'(acc);
  endfunction

  always @(posedge clk) if (fc_en) fc_result <= fc_eval(fc_data);
  always @(posedge clk) if (fc_en) pulses++;

  // Model: phase 0 collecting, 1 enable cycle, 2 capture cycle, 3 result offered.
  int          m_phase;
  int          m_cnt;
  logic [9:0]  m_vec [16];
  logic [31:0] exp_q [$];
  logic [9:0]  stim [16];

  function automatic logic [159:0] m_pack();
    logic [159:0] p;
    for (int k = 0; k < 16; k++) p[k*10 +: 10] = m_vec[k];
    return p;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("s_ready", 160'(s_ready), 160'(m_phase == 0));
    chk("fc_enable", 160'(fc_en), 160'(m_phase == 1 && !clr));
    chk("m_valid", 160'(m_valid), 160'(m_phase == 3));
    chk("count", 160'(cnt), 160'(m_cnt));
    chk("fc_data", fc_data, m_pack());
    if (m_phase == 3 && exp_q.size() > 0) chk("m_result", 160'(m_result), 160'(exp_q[0]));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input logic [9:0] d, input logic r, input logic c);
    sv = v; sd = d; mr = r; clr = c;
    #1 compare();
    @(posedge clk);
    if (c) begin
      exp_q.delete();
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (v) begin
          m_vec[m_cnt] = d;
          m_cnt++;
          if (m_cnt == 16) begin
            m_phase = 1;
            exp_q.push_back(fc_eval(m_pack()));
          end
        end
        1: m_phase = 2;
        2: m_phase = 3;
        default: if (r) begin
          void'(exp_q.pop_front());
          m_cnt   = 0;
          m_phase = 0;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sv = 1'b0; clr = 1'b0; mr = 1'b0; sd = '0;
    #1;
    m_phase = 0;
    m_cnt   = 0;
    for (int k = 0; k < 16; k++) m_vec[k] = '0;
    exp_q.delete();
    chk("rst_s_ready", 160'(s_ready), 160'(1));
    chk("rst_fc_enable", 160'(fc_en), 160'(0));
    chk("rst_m_valid", 160'(m_valid), 160'(0));
    chk("rst_count", 160'(cnt), 160'(0));
    chk("rst_fc_data", fc_data, 160'(0));
    chk("rst_m_result", 160'(m_result), 160'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic feed(input logic r);
    for (int k = 0; k < 16; k++) step(1'b1, stim[k], r, 1'b0);
  endtask

  task automatic fill_stim(input logic [9:0] val);
    for (int k = 0; k < 16; k++) stim[k] = val;
  endtask

  logic [159:0] snap;
  int           p0;

  initial begin
    rst = 1'b1; clr = 1'b0; sv = 1'b0; sd = '0; mr = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: all-zero vector gives the bias.
    fill_stim(10'd0);
    feed(1'b1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #1;
    chk("t1_valid", 160'(m_valid), 160'(1));
    chk("t1_result", 160'(m_result), 160'(32'd238));
    chk("t1_model", 160'(exp_q[0]), 160'(32'd238));
    step(0, 0, 1, 0);
    #1 chk("t1_valid_one_cycle", 160'(m_valid), 160'(0));

    // 2: all ones, latency from last accept.
    fill_stim(10'd1);
    feed(1'b1);
    #1 chk("t2_enable", 160'(fc_en), 160'(1));
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #1;
    chk("t2_result", 160'(m_result), 160'(32'd449));
    chk("t2_model", 160'(exp_q[0]), 160'(32'd449));
    step(0, 0, 1, 0);

    // 3: single one at element 4.
    fill_stim(10'd0);
    stim[4] = 10'd1;
    feed(1'b1);
    #1 snap = fc_data;
    chk("t3_elem4", 160'(snap[49:40]), 160'(10'd1));
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #1 chk("t3_result", 160'(m_result), 160'(32'hFFFFFEE4));
    step(0, 0, 1, 0);

    // 4: downstream stall holds the result.
    fill_stim(10'd1);
    feed(1'b0);
    p0 = pulses;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1 chk("t4_hold_result", 160'(m_result), 160'(32'd449));
      step(1, 10'd5, 0, 0);
    end
    chk("t4_no_second_enable", 160'(pulses - p0), 160'(1));
    step(0, 0, 1, 0);

    // 5: partial vector aborted by clear.
    for (int k = 0; k < 7; k++) step(1, 10'($urandom_range(0, 1023)), 0, 0);
    #1 chk("t5_count7", 160'(cnt), 160'(7));
    step(1, 10'd3, 0, 1);
    #1 chk("t5_count_cleared", 160'(cnt), 160'(0));
    p0 = pulses;
    fill_stim(10'd1);
    feed(1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1 chk("t5_result", 160'(m_result), 160'(32'd449));
    step(0, 0, 1, 0);
    chk("t5_one_enable", 160'(pulses - p0), 160'(1));

    // 6: reset during FIRE and during OUT.
    feed(1'b0);
    #1 chk("t6_in_fire", 160'(fc_en), 160'(1));
    do_reset();
    feed(1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1 chk("t6_in_out", 160'(m_valid), 160'(1));
    do_reset();

    // Random traffic, occasional clears.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 9) < 7), 10'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
